// File: rtl/my_gpio.sv
// my_gpio: memory-mapped output port with DATA/SET/CLR/TGL aliases.
module my_gpio #(
  parameter logic [31:0]      BASE_ADDR = 32'h0000_0030,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] gpio_out
);
  logic [WIDTH-1:0] r_latch;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_next;
  logic             w_sel_data;
  logic             w_sel_set;
  logic             w_sel_clr;
  logic             w_sel_tgl;
  assign w_wd       = wdata[WIDTH-1:0];
  assign w_sel_data = addr == BASE_ADDR;
  assign w_sel_set  = addr == BASE_ADDR + 32'h4;
  assign w_sel_clr  = addr == BASE_ADDR + 32'h8;
  assign w_sel_tgl  = addr == BASE_ADDR + 32'hC;
  // unmapped addresses fall through to the current value, so a stray write is a no-op
  always_comb begin
    w_next = w_sel_data ? w_wd :
             w_sel_set  ? (r_latch | w_wd) :
             w_sel_clr  ? (r_latch & ~w_wd) :
             w_sel_tgl  ? (r_latch ^ w_wd) : r_latch;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_latch <= RST_VAL;
    else if (we) r_latch <= w_next;
  end
  assign rdata    = w_sel_data ? 32'(r_latch) : 32'h0;
  assign gpio_out = r_latch;
  generate
    if (WIDTH < 32) begin : g_pad
      logic w_unused;
      assign w_unused = ^wdata[31:WIDTH];
    end
  endgenerate
endmodule

// File: tb/tb_my_gpio.sv
// tb_my_gpio: directed checks of the GPIO register map, reset and aliases.
module tb_my_gpio;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [7:0]  gpio_out;
  int n_cmp = 0;
  int n_bad = 0;

  my_gpio dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .we(we), .rdata(rdata), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a falling edge; the write lands on the next rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 check(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = 32'h30; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gpio", {24'h0, gpio_out}, 32'h00);
    rd("rst_rdata", 32'h30, 32'h0);
    addr = 32'h30; wdata = 32'hAA; we = 1'b1;
    @(negedge clk);
    check("wr_in_rst", {24'h0, gpio_out}, 32'h00);
    we = 1'b0;
    rst = 1'b0;
    wr(32'h30, 32'hAA);
    check("data_aa", {24'h0, gpio_out}, 32'hAA);
    rd("rd_aa", 32'h30, 32'hAA);
    addr = 32'h30; wdata = 32'hFFFF_FF55; we = 1'b1;
    #1 check("pre_edge", rdata, 32'hAA);
    @(negedge clk);
    we = 1'b0;
    check("upper_ign", {24'h0, gpio_out}, 32'h55);
    rd("rd_55", 32'h30, 32'h55);
    wr(32'h30, 32'hAA);
    wr(32'h34, 32'h05);
    check("set", {24'h0, gpio_out}, 32'hAF);
    rd("rd_set", 32'h34, 32'h0);
    wr(32'h38, 32'h0F);
    check("clr", {24'h0, gpio_out}, 32'hA0);
    rd("rd_clr", 32'h38, 32'h0);
    wr(32'h3C, 32'hFF);
    check("tgl", {24'h0, gpio_out}, 32'h5F);
    rd("rd_tgl", 32'h3C, 32'h0);
    rd("rd_5f", 32'h30, 32'h5F);
    wr(32'h40, 32'h12);
    check("unmap_40", {24'h0, gpio_out}, 32'h5F);
    wr(32'h31, 32'h12);
    check("unmap_31", {24'h0, gpio_out}, 32'h5F);
    rd("rd_40", 32'h40, 32'h0);
    rd("rd_31", 32'h31, 32'h0);
    wr(32'h3C, 32'hF0);
    wr(32'h34, 32'h01);
    wr(32'h38, 32'h80);
    check("b2b", {24'h0, gpio_out}, 32'h2F);
    wr(32'h30, 32'h5F);
    #2 rst = 1'b1;
    #1 check("async_rst", {24'h0, gpio_out}, 32'h00);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hold", {24'h0, gpio_out}, 32'h00);
    addr = 32'h30; wdata = 32'h77; we = 1'b1;
    #1 rst = 1'b1;
    #1 check("rst_pend", {24'h0, gpio_out}, 32'h00);
    #1 rst = 1'b0;
    @(negedge clk);
    we = 1'b0;
    check("first_wr", {24'h0, gpio_out}, 32'h77);
    rd("rd_77", 32'h30, 32'h77);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
